mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous inst/data RAM between the IF stage (fetch) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch (IF) port and the load/store (MEM) port of the core.
// One access is granted per cycle; the RAM answers one cycle later, when the
// granted port sees a single-cycle ready pulse together with its read data.
// While one port is in its access cycle, the other port may be granted, so
// two continuously requesting ports alternate at full RAM bandwidth.
//
// Build option: define MEM_ARB_RR_EN to resolve idle-state ties by
// alternating on last_grant; without it, a tie always goes to the data port.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   // instruction fetch port
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ready,
   // load/store port
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_sel,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ready,
   // RAM side
   output logic                ram_ce,
   output logic                ram_we,
   output logic [DATA_W/8-1:0] ram_sel,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_wdata,
   input  logic [DATA_W-1:0]   ram_rdata,
   // pipeline stall requests
   output logic                stallreq_if,
   output logic                stallreq_mem
);

   localparam int SEL_W = DATA_W / 8;

   // IDLE: no access in flight; I_ACC/D_ACC: RAM is returning that port's data
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_ACC = 2'd1,
      D_ACC = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_D    = 2'd2
   } grant_t;

   state_t state;
   state_t state_nxt;
   grant_t grant;
   logic   tie_to_if;
   // write/read flavour of the data access now in its ACC cycle
   logic   acc_we_p0;

   // Choice among the ports when nothing is in flight; tie_if selects the
   // fetch port when both are requesting.
   function automatic grant_t idle_pick(input logic ireq, input logic dreq,
                                        input logic tie_if);
      grant_t g;
      g = GNT_NONE;
      if (ireq && dreq)
         g = tie_if ? GNT_IF : GNT_D;
      else if (dreq)
         g = GNT_D;
      else if (ireq)
         g = GNT_IF;
      return g;
   endfunction

`ifdef MEM_ARB_RR_EN
   // 0 = fetch port won the most recent grant, 1 = data port won it
   logic last_grant;

   assign tie_to_if = last_grant;

   // Remember the winner of every grant so the next idle tie goes the other way
   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 1'b0;
      else if (grant == GNT_IF)
         last_grant <= 1'b0;
      else if (grant == GNT_D)
         last_grant <= 1'b1;
   end
`else
   assign tie_to_if = 1'b0;
`endif

   // Grant selection and next state; reset suppresses every grant
   always_comb begin
      grant     = GNT_NONE;
      state_nxt = IDLE;
      if (!rst) begin
         case (state)
            IDLE:    grant = idle_pick(if_req, d_req, tie_to_if);
            // the completing port is never re-granted in its own ready cycle
            I_ACC:   if (d_req)  grant = GNT_D;
            D_ACC:   if (if_req) grant = GNT_IF;
            default: grant = GNT_NONE;
         endcase
         case (grant)
            GNT_IF:  state_nxt = I_ACC;
            GNT_D:   state_nxt = D_ACC;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register; reset abandons any in-flight access
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Capture the access type at grant so write completions return zero data
   always_ff @(posedge clk) begin
      if (grant == GNT_D)
         acc_we_p0 <= d_we;
   end

   // RAM request for the granted port; everything idles at zero otherwise
   always_comb begin
      ram_ce    = 1'b0;
      ram_we    = 1'b0;
      ram_sel   = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (grant)
         GNT_IF: begin
            ram_ce   = 1'b1;
            ram_sel  = {SEL_W{1'b1}};
            ram_addr = if_addr;
         end
         GNT_D: begin
            ram_ce    = 1'b1;
            ram_we    = d_we;
            ram_sel   = d_we ? d_sel : {SEL_W{1'b1}};
            ram_addr  = d_addr;
            ram_wdata = d_we ? d_wdata : '0;
         end
         default: begin
            ram_ce = 1'b0;
         end
      endcase
   end

   // ---- access stage: completion pulses, returned data, stall requests ----
   // Completion pulses and read data for the port whose access cycle this is
   always_comb begin
      if_ready     = !rst && (state == I_ACC);
      d_ready      = !rst && (state == D_ACC);
      if_rdata     = if_ready ? ram_rdata : '0;
      d_rdata      = (d_ready && !acc_we_p0) ? ram_rdata : '0;
      stallreq_if  = !rst && if_req && !if_ready;
      stallreq_mem = !rst && d_req && !d_ready;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic on
// both ports, with a behavioural RAM and a transaction-level reference model.
// Honours MEM_ARB_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              d_req;
   logic              d_we;
   logic [SEL_W-1:0]  d_sel;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              ram_ce;
   logic              ram_we;
   logic [SEL_W-1:0]  ram_sel;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              stallreq_if;
   logic              stallreq_mem;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
   );

   // initial RAM contents: word 1 holds an instruction, word 4 starts cleared
   function automatic logic [31:0] init_word(input int i);
      logic [31:0] w;
      if (i == 1)      w = 32'h3401_1100;
      else if (i == 4) w = 32'h0000_0000;
      else             w = 32'hA500_0000 + i * 32'h0001_0307;
      return w;
   endfunction

   // behavioural synchronous single-port RAM, 64 words, read data one cycle later
   logic        ram_init;
   logic [31:0] ram_mem [64];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
      end else if (ram_ce) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_sel[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
         end else begin
            ram_rdata <= ram_mem[ram_addr[7:2]];
         end
      end
   end

   // ---------------- reference model ----------------
   // m_owner: which port is in its completion cycle (0 none, 1 fetch, 2 data)
   int          m_owner;
   bit          m_we;
   logic [31:0] m_exp;
   logic [31:0] sh_mem [64];
`ifdef MEM_ARB_RR_EN
   bit          m_last_data;
`endif
   int          e_gnt;
   bit          seen_if_rdy;
   bit          seen_d_rdy;

   function automatic bit tie_goes_to_if();
`ifdef MEM_ARB_RR_EN
      return m_last_data;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // who the rules say gets the RAM this cycle
   task automatic model_eval();
      e_gnt = 0;
      if (!rst) begin
         if (m_owner == 1)      e_gnt = d_req  ? 2 : 0;
         else if (m_owner == 2) e_gnt = if_req ? 1 : 0;
         else if (if_req && d_req) e_gnt = tie_goes_to_if() ? 1 : 2;
         else if (d_req)        e_gnt = 2;
         else if (if_req)       e_gnt = 1;
      end
   endtask

   task automatic check_outputs();
      bit          xi;
      bit          xd;
      logic [3:0]  xsel;
      logic [31:0] xaddr;
      xi = !rst && (m_owner == 1);
      xd = !rst && (m_owner == 2);
      seen_if_rdy = xi;
      seen_d_rdy  = xd;
      chk("if_ready", if_ready, xi);
      chk("d_ready", d_ready, xd);
      chk("if_rdata", if_rdata, xi ? m_exp : 32'h0);
      chk("d_rdata", d_rdata, (xd && !m_we) ? m_exp : 32'h0);
      chk("stallreq_if", stallreq_if, !rst && if_req && !xi);
      chk("stallreq_mem", stallreq_mem, !rst && d_req && !xd);
      chk("ram_ce", ram_ce, e_gnt != 0);
      chk("ram_we", ram_we, (e_gnt == 2) && d_we);
      xsel  = (e_gnt == 0) ? 4'h0 : ((e_gnt == 2 && d_we) ? d_sel : 4'hF);
      xaddr = (e_gnt == 0) ? 32'h0 : ((e_gnt == 1) ? if_addr : d_addr);
      chk("ram_sel", ram_sel, xsel);
      chk("ram_addr", ram_addr, xaddr);
      if (e_gnt == 0)
         chk("ram_wdata_idle", ram_wdata, 32'h0);
      else if (e_gnt == 2 && d_we)
         chk("ram_wdata_store", ram_wdata, d_wdata);
   endtask

   task automatic model_commit();
      if (rst) begin
         m_owner = 0;
`ifdef MEM_ARB_RR_EN
         m_last_data = 1'b0;
`endif
      end else begin
         m_owner = e_gnt;
         if (e_gnt == 1) m_exp = sh_mem[if_addr[7:2]];
         if (e_gnt == 2) begin
            m_we = d_we;
            if (d_we) begin
               for (int b = 0; b < 4; b++)
                  if (d_sel[b]) sh_mem[d_addr[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end else begin
               m_exp = sh_mem[d_addr[7:2]];
            end
         end
`ifdef MEM_ARB_RR_EN
         if (e_gnt != 0) m_last_data = (e_gnt == 2);
`endif
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval();
      check_outputs();
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   // release any port whose completion pulse was just seen
   task automatic drop_done();
      if (seen_if_rdy) if_req = 1'b0;
      if (seen_d_rdy)  d_req  = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom();
      a[1:0] = 2'b00;
      return a;
   endfunction

   task automatic rand_drive();
      drop_done();
      if (if_req && m_owner != 1 && $urandom_range(0, 15) == 0)
         if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
         if_req  = 1'b1;
         if_addr = rand_addr();
      end
      if (d_req && m_owner != 2 && $urandom_range(0, 15) == 0)
         d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
         d_req   = 1'b1;
         d_we    = 1'($urandom_range(0, 1));
         d_sel   = 4'($urandom_range(0, 15));
         d_addr  = rand_addr();
         d_wdata = $urandom();
      end
   endtask

   initial begin
      m_owner = 0;
      m_we    = 1'b0;
      m_exp   = 32'h0;
      e_gnt   = 0;
      seen_if_rdy = 1'b0;
      seen_d_rdy  = 1'b0;
`ifdef MEM_ARB_RR_EN
      m_last_data = 1'b0;
`endif
      for (int i = 0; i < 64; i++) sh_mem[i] = init_word(i);

      // reset held with both ports requesting
      rst = 1'b1; ram_init = 1'b1;
      if_req = 1'b1; if_addr = 32'h0000_0004;
      d_req = 1'b1; d_we = 1'b0; d_sel = 4'h0; d_addr = 32'h0000_0020; d_wdata = 32'h0;
      for (int i = 0; i < 10; i++) begin
         settle();
         chk("rst_hold_ce", ram_ce, 1'b0);
         chk("rst_hold_stall_mem", stallreq_mem, 1'b0);
         advance();
         ram_init = 1'b0;
      end
      rst = 1'b0;
      settle();
      chk("after_rst_data_first", ram_addr, 32'h0000_0020);
      advance();
      settle();
      chk("after_rst_d_ready", d_ready, 1'b1);
      chk("after_rst_d_rdata", d_rdata, init_word(8));
      chk("after_rst_if_granted", ram_addr, 32'h0000_0004);
      advance(); drop_done();
      settle();
      chk("after_rst_if_rdata", if_rdata, 32'h3401_1100);
      advance(); drop_done();
      settle(); advance();

      // lone fetch
      if_req = 1'b1; if_addr = 32'h0000_0004;
      settle();
      chk("fetch_grant_ce", ram_ce, 1'b1);
      chk("fetch_grant_addr", ram_addr, 32'h0000_0004);
      chk("fetch_grant_stall", stallreq_if, 1'b1);
      advance();
      settle();
      chk("fetch_ready", if_ready, 1'b1);
      chk("fetch_rdata", if_rdata, 32'h3401_1100);
      chk("fetch_ready_stall", stallreq_if, 1'b0);
      advance(); drop_done();
      settle(); advance();

      // partial store then load of the same word
      d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h0000_0010; d_wdata = 32'hDEAD_BEEF;
      settle();
      chk("store_we", ram_we, 1'b1);
      chk("store_sel", ram_sel, 4'b0011);
      advance();
      settle();
      chk("store_ready", d_ready, 1'b1);
      chk("store_rdata_zero", d_rdata, 32'h0);
      advance(); drop_done();
      settle(); advance();
      d_req = 1'b1; d_we = 1'b0; d_sel = 4'b0000; d_addr = 32'h0000_0010;
      settle();
      chk("load_sel_all", ram_sel, 4'hF);
      advance();
      settle();
      chk("load_rdata", d_rdata, 32'h0000_BEEF);
      advance(); drop_done();
      settle(); advance();

      // contention: both held continuously
      if_req = 1'b1; if_addr = 32'h0000_0008;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0030;
      for (int k = 0; k < 12; k++) begin
         settle();
`ifndef MEM_ARB_RR_EN
         chk("contend_order", ram_addr, ((k % 2) == 0) ? 32'h0000_0030 : 32'h0000_0008);
`endif
         if (k > 0) chk("contend_one_ready", 64'(if_ready) + 64'(d_ready), 64'd1);
         advance();
      end
      if_req = 1'b0; d_req = 1'b0;
      settle(); advance();
      settle(); advance();

      // idle tie right after a data grant
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
      settle(); advance();
      settle(); advance(); drop_done();
      settle(); advance();
      if_req = 1'b1; if_addr = 32'h0000_0004;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0044;
      settle();
`ifdef MEM_ARB_RR_EN
      chk("tie_after_data", ram_addr, 32'h0000_0004);
`else
      chk("tie_after_data", ram_addr, 32'h0000_0044);
`endif
      advance(); drop_done();
      for (int k = 0; k < 3; k++) begin
         settle(); advance(); drop_done();
      end

      // reset during a data access
      if_req = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008;
      settle(); advance();
      rst = 1'b1;
      settle();
      chk("mid_rst_no_ready", d_ready, 1'b0);
      chk("mid_rst_rdata", d_rdata, 32'h0);
      advance();
      rst = 1'b0;
      settle();
      chk("post_rst_regrant_ce", ram_ce, 1'b1);
      chk("post_rst_regrant_addr", ram_addr, 32'h0000_0008);
      advance();
      settle();
      chk("post_rst_ready", d_ready, 1'b1);
      advance(); drop_done();

      // randomized traffic on both ports
      for (int n = 0; n < 600; n++) begin
         settle();
         advance();
         rand_drive();
      end
      if_req = 1'b0; d_req = 1'b0;
      for (int n = 0; n < 4; n++) begin
         settle(); advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
